// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow_memory between D-cache (port 0) and I-cache (port 1), one transaction at a time
//   p0_*/p1_*  : requester ports (read/write level requests, line address, write line, read line, ready pulse)
//   mem_*      : registered request to slow_memory plus its read line and ready pulse
//   busy       : a transaction is outstanding
//   timeout_err: sticky watchdog flag, cleared only by rst_n
module mem_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic want0, want1, pick, gnt, last_grant, expire;
  logic [15:0] wd;
  assign want0 = p0_read | p0_write;
  assign want1 = p1_read | p1_write;
  // pick = 1 selects port 1; last_grant resets to 1 so port 0 wins the first tie
  assign pick = (want0 & want1) ? (PRIO_MODE == 1 ? 1'b0 : ~last_grant) : ~want0;
  assign expire = wd == 16'(TIMEOUT - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (want0 | want1) ? BUSY : IDLE;
      BUSY:    state_nx = (mem_ready | expire) ? DONE : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      wd          <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      p0_ready    <= 1'b0;
      p1_ready    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      if (state == IDLE && (want0 | want1)) begin
        // read and write together means write
        gnt       <= pick;
        mem_write <= pick ? p1_write : p0_write;
        mem_read  <= pick ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
        mem_addr  <= pick ? p1_addr : p0_addr;
        mem_wdata <= pick ? p1_wdata : p0_wdata;
        wd        <= '0;
      end
      if (state == BUSY) begin
        if (mem_ready) begin
          if (mem_read && gnt)  p1_rdata <= mem_rdata;
          if (mem_read && !gnt) p0_rdata <= mem_rdata;
          p0_ready   <= ~gnt;
          p1_ready   <= gnt;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          wd         <= '0;
          last_grant <= gnt;
        end else if (expire) begin
          timeout_err <= 1'b1;
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          wd          <= '0;
        end else begin
          wd <= wd + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for round-robin (a) and fixed-priority/short-watchdog (b) arbiters
module tb_mem_arbiter;
  logic clk, rst_n, sel;
  logic p0_read, p0_write, p1_read, p1_write, mr0, mr1;
  logic [27:0] p0_addr, p1_addr;
  logic [127:0] p0_wdata, p1_wdata, mdata;
  logic [127:0] a_p0_rdata, a_p1_rdata, a_mem_wdata, b_p0_rdata, b_p1_rdata, b_mem_wdata;
  logic [27:0] a_mem_addr, b_mem_addr;
  logic a_p0_ready, a_p1_ready, a_mem_read, a_mem_write, a_busy, a_to;
  logic b_p0_ready, b_p1_ready, b_mem_read, b_mem_write, b_busy, b_to;
  logic s_p0_ready, s_p1_ready, s_mem_read, s_mem_write, s_busy;
  logic [127:0] s_p0_rdata, s_p1_rdata, s_mem_wdata;
  logic [27:0] s_mem_addr;
  int checks = 0, errors = 0;
  typedef struct {logic port; logic [127:0] data;} exp_t;
  exp_t sb[$];
  logic [127:0] d1, d2, d3, d4, d5, w;

  mem_arbiter #(.PRIO_MODE(0), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(a_p0_rdata), .p0_ready(a_p0_ready),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(a_p1_rdata), .p1_ready(a_p1_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mdata), .mem_ready(mr0), .busy(a_busy), .timeout_err(a_to));

  mem_arbiter #(.PRIO_MODE(1), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(b_p0_rdata), .p0_ready(b_p0_ready),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(b_p1_rdata), .p1_ready(b_p1_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mdata), .mem_ready(mr1), .busy(b_busy), .timeout_err(b_to));

  assign s_p0_ready  = sel ? b_p0_ready  : a_p0_ready;
  assign s_p1_ready  = sel ? b_p1_ready  : a_p1_ready;
  assign s_mem_read  = sel ? b_mem_read  : a_mem_read;
  assign s_mem_write = sel ? b_mem_write : a_mem_write;
  assign s_busy      = sel ? b_busy      : a_busy;
  assign s_p0_rdata  = sel ? b_p0_rdata  : a_p0_rdata;
  assign s_p1_rdata  = sel ? b_p1_rdata  : a_p1_rdata;
  assign s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic serve(input int lat, input logic [127:0] rd, input logic [27:0] ea,
                       input logic ew, input logic [127:0] ewd);
    int n = 0;
    exp_t e;
    while (!(s_mem_read || s_mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 128'(n < 20), 1);
    chk("mem_addr", s_mem_addr, ea);
    chk("mem_write", s_mem_write, ew);
    chk("mem_read", s_mem_read, !ew);
    if (ew) chk("mem_wdata", s_mem_wdata, ewd);
    chk("busy", s_busy, 1);
    repeat (lat) @(negedge clk);
    chk("mem_addr_held", s_mem_addr, ea);
    chk("no_early_ready", s_p0_ready | s_p1_ready, 0);
    mdata = rd;
    if (sel) mr1 = 1; else mr0 = 1;
    @(negedge clk);
    mr0 = 0;
    mr1 = 0;
    chk("sb_nonempty", 128'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ready_win", e.port ? s_p1_ready : s_p0_ready, 1);
      chk("ready_other", e.port ? s_p0_ready : s_p1_ready, 0);
      chk("rdata", e.port ? s_p1_rdata : s_p0_rdata, e.data);
    end
    chk("mem_released", s_mem_read | s_mem_write, 0);
  endtask

  task automatic fall();
    @(negedge clk);
    chk("ready_fall", s_p0_ready | s_p1_ready, 0);
    chk("idle_gap", s_busy | s_mem_read | s_mem_write, 0);
  endtask

  initial begin
    rst_n = 1; sel = 0; mr0 = 0; mr1 = 0; mdata = '0;
    p0_read = 0; p0_write = 0; p0_addr = '0; p0_wdata = '0;
    p1_read = 0; p1_write = 0; p1_addr = '0; p1_wdata = '0;
    d1 = {4{32'h1111_0001}}; d2 = {4{32'h2222_0002}}; d3 = {4{32'h3333_0003}};
    d4 = {4{32'h4444_0004}}; d5 = {4{32'h5555_0005}}; w = {8{16'h1234}};
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_a_outputs", {a_p0_ready, a_p1_ready, a_mem_read, a_mem_write, a_busy, a_to}, 0);
    chk("rst_a_data", a_p0_rdata | a_p1_rdata | a_mem_wdata | 128'(a_mem_addr), 0);
    chk("rst_b_outputs", {b_p0_ready, b_p1_ready, b_mem_read, b_mem_write, b_busy, b_to}, 0);
    @(negedge clk);
    rst_n = 1;
    // single read on port 0 with a slow memory
    p0_read = 1; p0_addr = 28'h10;
    sb.push_back('{1'b0, {16{8'hA5}}});
    serve(17, {16{8'hA5}}, 28'h10, 0, 0);
    p0_read = 0;
    fall();
    chk("t1_p1_rdata", a_p1_rdata, 0);
    // round-robin ties
    do_reset();
    p0_read = 1; p0_addr = 28'h20; p1_read = 1; p1_addr = 28'h30;
    sb.push_back('{1'b0, d1});
    serve(3, d1, 28'h20, 0, 0);
    p0_read = 0;
    fall();
    sb.push_back('{1'b1, d2});
    serve(3, d2, 28'h30, 0, 0);
    p1_read = 0;
    fall();
    p0_read = 1; p1_read = 1;
    sb.push_back('{1'b0, d3});
    serve(2, d3, 28'h20, 0, 0);
    p0_addr = 28'h21;
    fall();
    sb.push_back('{1'b1, d4});
    serve(2, d4, 28'h30, 0, 0);
    p1_read = 0;
    fall();
    sb.push_back('{1'b0, d5});
    serve(2, d5, 28'h21, 0, 0);
    p0_read = 0;
    fall();
    // write then read back; read+write together is a write
    p1_read = 1; p1_write = 1; p1_addr = 28'h3; p1_wdata = w;
    sb.push_back('{1'b1, d4});
    serve(5, {16{8'hEE}}, 28'h3, 1, w);
    p1_read = 0; p1_write = 0;
    fall();
    p0_read = 1; p0_addr = 28'h3;
    sb.push_back('{1'b0, w});
    serve(4, w, 28'h3, 0, 0);
    p0_read = 0;
    fall();
    chk("t4_p1_rdata_kept", a_p1_rdata, d4);
    // reset in the middle of BUSY, then a late mem_ready
    p0_read = 1; p0_addr = 28'h40;
    repeat (3) @(negedge clk);
    chk("t6_busy_before", {a_busy, a_mem_read}, 2'b11);
    rst_n = 0;
    #1;
    chk("t6_cleared", {a_busy, a_mem_read, a_mem_write, a_p0_ready, a_p1_ready}, 0);
    chk("t6_addr_cleared", a_mem_addr, 0);
    @(negedge clk);
    rst_n = 1; p0_read = 0; mr0 = 1; mdata = d1;
    @(negedge clk);
    mr0 = 0;
    chk("t6_late_ready", {a_p0_ready, a_p1_ready, a_busy}, 0);
    chk("t6_rdata", a_p0_rdata, 0);
    // fixed priority: port 0 wins every time while both request
    sel = 1;
    do_reset();
    p0_read = 1; p0_addr = 28'h60; p1_read = 1; p1_addr = 28'h70;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, d1 + 128'(i)});
      serve(2, d1 + 128'(i), 28'h60, 0, 0);
      fall();
    end
    p0_read = 0; p1_read = 0;
    chk("t3_sb_empty", 128'(sb.size()), 0);
    chk("t3_p1_never", b_p1_rdata, 0);
    // watchdog with a memory that never answers
    do_reset();
    p0_read = 1; p0_addr = 28'h50;
    repeat (8) @(negedge clk);
    chk("t5_no_timeout_yet", {b_to, b_busy}, 2'b01);
    @(negedge clk);
    chk("t5_timeout", {b_to, b_p0_ready, b_mem_read, b_busy}, 4'b1001);
    p0_read = 0;
    @(negedge clk);
    chk("t5_idle", {b_to, b_busy}, 2'b10);
    repeat (5) @(negedge clk);
    chk("t5_sticky", b_to, 1);
    rst_n = 0;
    #1;
    chk("t5_reset_clears", b_to, 0);
    @(negedge clk);
    rst_n = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
